// File: rtl/multi_track_pkg.sv
// Shared types and helpers for the multi-track record/playback controller.
package multi_track_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT       = 3'd1,
        ST_RECD       = 3'd2,
        ST_RECD_PAUSE = 3'd3,
        ST_PLAY       = 3'd4,
        ST_PLAY_PAUSE = 3'd5
    } state_t;

    // Words per track region: the SRAM split evenly across all tracks.
    function automatic int unsigned region_words(input int unsigned addr_w,
                                                 input int unsigned n_track);
        return 32'((64'd1 << addr_w) / 64'(n_track));
    endfunction

endpackage

// File: rtl/sec_timer.sv
// Elapsed-seconds timer: tick counter, slow-play divider and saturating seconds.
module sec_timer #(
    parameter int unsigned TICKS_PER_SEC = 12_000_000,
    parameter int unsigned SEC_W         = 6,
    parameter int unsigned SPEED_W       = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               run,
    input  logic               clear,
    input  logic               fast,
    input  logic [SPEED_W-1:0] speed,
    output logic [SEC_W-1:0]   seconds
);

    localparam int unsigned TICK_W = $clog2(TICKS_PER_SEC + (2 ** SPEED_W)) + 1;
    localparam logic [SEC_W-1:0] SEC_MAX = {SEC_W{1'b1}};

    logic [TICK_W-1:0]  tick_cnt;
    logic [TICK_W-1:0]  step;
    logic [TICK_W-1:0]  sum;
    logic               wrap;
    logic [SPEED_W-1:0] div_cnt;

    // Fast play advances the tick counter by the speed factor every cycle.
    always_comb begin
        step = fast ? (TICK_W'(speed) + TICK_W'(1)) : TICK_W'(1);
        sum  = tick_cnt + step;
        wrap = (sum >= TICK_W'(TICKS_PER_SEC));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
            div_cnt  <= '0;
            seconds  <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
            div_cnt  <= '0;
            seconds  <= '0;
        end else if (run) begin
            if (wrap) begin
                tick_cnt <= sum - TICK_W'(TICKS_PER_SEC);
                // Slow play only credits a second every (speed+1) tick periods.
                if (fast || (div_cnt >= speed)) begin
                    div_cnt <= '0;
                    if (seconds != SEC_MAX) begin
                        seconds <= seconds + SEC_W'(1);
                    end
                end else begin
                    div_cnt <= div_cnt + SPEED_W'(1);
                end
            end else begin
                tick_cnt <= sum;
            end
        end
    end

endmodule

// File: rtl/multi_track_ctrl.sv
// Top-level record/playback FSM with per-track length/valid table.
// Optional build macro LOOP_PLAY_EN: end-of-track in PLAY restarts the track instead of stopping.
module multi_track_ctrl
    import multi_track_pkg::*;
#(
    parameter int unsigned N_TRACK       = 4,
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned TICKS_PER_SEC = 12_000_000,
    parameter int unsigned SEC_W         = 6,
    parameter int unsigned SPEED_W       = 3,
    localparam int unsigned TW           = (N_TRACK > 1) ? $clog2(N_TRACK) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_init_done,
    input  logic               i_key_rec,
    input  logic               i_key_play,
    input  logic               i_key_stop,
    input  logic [TW-1:0]      i_track,
    input  logic               i_fast,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic [ADDR_W-1:0]  i_rec_addr,
    input  logic               i_play_done,
    output logic [2:0]         o_state,
    output logic               o_rec_run,
    output logic               o_rec_pause,
    output logic               o_play_run,
    output logic               o_play_pause,
    output logic               o_stop,
    output logic               o_sram_wr,
    output logic [ADDR_W-1:0]  o_base_addr,
    output logic [ADDR_W-1:0]  o_play_len,
    output logic [N_TRACK-1:0] o_track_valid,
    output logic [SEC_W-1:0]   o_seconds
);

    localparam int unsigned REGION = region_words(ADDR_W, N_TRACK);
    localparam int unsigned REG_SH = $clog2(REGION);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REGION - 1);
    localparam logic [ADDR_W-1:0] FULL_LEN  = ADDR_W'(REGION);

    state_t              state_r;
    state_t              state_nxt;
    logic [TW-1:0]       trk_r;
    logic [ADDR_W-1:0]   len_tbl [N_TRACK];
    logic                latch_trk;
    logic                tbl_wr;
    logic [ADDR_W-1:0]   tbl_len;
    logic                loop_restart;
    logic                tmr_clear;
    logic                tmr_run;
    logic                tmr_fast;
    logic [SPEED_W-1:0]  tmr_speed;

    // Next-state and table-update decode.
    always_comb begin
        state_nxt    = state_r;
        latch_trk    = 1'b0;
        tbl_wr       = 1'b0;
        tbl_len      = i_rec_addr;
        loop_restart = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_init_done) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_key_rec) begin
                    state_nxt = ST_RECD;
                    latch_trk = 1'b1;
                end else if (i_key_play && o_track_valid[i_track]) begin
                    state_nxt = ST_PLAY;
                    latch_trk = 1'b1;
                end
            end
            ST_RECD: begin
                if (i_key_stop) begin
                    state_nxt = ST_WAIT;
                    tbl_wr    = 1'b1;
                end else if (i_rec_addr == LAST_ADDR) begin
                    state_nxt = ST_WAIT;
                    tbl_wr    = 1'b1;
                    tbl_len   = FULL_LEN;
                end else if (i_key_rec) begin
                    state_nxt = ST_RECD_PAUSE;
                end
            end
            ST_RECD_PAUSE: begin
                if (i_key_stop) begin
                    state_nxt = ST_WAIT;
                    tbl_wr    = 1'b1;
                end else if (i_key_rec) begin
                    state_nxt = ST_RECD;
                end
            end
            ST_PLAY: begin
                if (i_key_stop) begin
                    state_nxt = ST_WAIT;
                end else if (i_play_done) begin
`ifdef LOOP_PLAY_EN
                    loop_restart = 1'b1;
`else
                    state_nxt = ST_WAIT;
`endif
                end else if (i_key_play) begin
                    state_nxt = ST_PLAY_PAUSE;
                end
            end
            ST_PLAY_PAUSE: begin
                if (i_key_stop) begin
                    state_nxt = ST_WAIT;
                end else if (i_key_play) begin
                    state_nxt = ST_PLAY;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_clear = ((state_nxt == ST_WAIT) && (state_r != ST_WAIT)) || loop_restart;
        tmr_run   = (state_r == ST_RECD) || (state_r == ST_PLAY);
        tmr_fast  = (state_r == ST_PLAY) && i_fast;
        tmr_speed = (state_r == ST_PLAY) ? i_speed : '0;
    end

    // State, control outputs and track table; outputs follow the next state so they align with state_r.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            trk_r         <= '0;
            o_track_valid <= '0;
            o_rec_run     <= 1'b0;
            o_rec_pause   <= 1'b0;
            o_play_run    <= 1'b0;
            o_play_pause  <= 1'b0;
            o_stop        <= 1'b0;
            o_sram_wr     <= 1'b0;
            o_base_addr   <= '0;
            o_play_len    <= '0;
            for (int i = 0; i < int'(N_TRACK); i++) begin
                len_tbl[i] <= '0;
            end
        end else begin
            state_r      <= state_nxt;
            o_rec_run    <= (state_nxt == ST_RECD);
            o_sram_wr    <= (state_nxt == ST_RECD);
            o_rec_pause  <= (state_nxt == ST_RECD_PAUSE);
            o_play_run   <= (state_nxt == ST_PLAY) && !loop_restart;
            o_play_pause <= (state_nxt == ST_PLAY_PAUSE);
            o_stop       <= (state_nxt == ST_WAIT);
            if (latch_trk) begin
                trk_r       <= i_track;
                o_base_addr <= ADDR_W'(i_track) << REG_SH;
                o_play_len  <= len_tbl[i_track];
            end
            if (tbl_wr) begin
                len_tbl[trk_r]       <= tbl_len;
                o_track_valid[trk_r] <= (tbl_len != '0);
                o_play_len           <= tbl_len;
            end
        end
    end

    assign o_state = state_r;

    sec_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .SEC_W         (SEC_W),
        .SPEED_W       (SPEED_W)
    ) u_sec_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .run     (tmr_run),
        .clear   (tmr_clear),
        .fast    (tmr_fast),
        .speed   (tmr_speed),
        .seconds (o_seconds)
    );

endmodule

// File: tb/tb_multi_track_ctrl.sv
// Directed self-checking bench for multi_track_ctrl (4 tracks, 20-bit address, 100 ticks/second).
module tb_multi_track_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_init_done;
    logic        i_key_rec;
    logic        i_key_play;
    logic        i_key_stop;
    logic [1:0]  i_track;
    logic        i_fast;
    logic [2:0]  i_speed;
    logic [19:0] i_rec_addr;
    logic        i_play_done;
    logic [2:0]  o_state;
    logic        o_rec_run;
    logic        o_rec_pause;
    logic        o_play_run;
    logic        o_play_pause;
    logic        o_stop;
    logic        o_sram_wr;
    logic [19:0] o_base_addr;
    logic [19:0] o_play_len;
    logic [3:0]  o_track_valid;
    logic [5:0]  o_seconds;

    int passed = 0;
    int total  = 0;

    multi_track_ctrl #(
        .N_TRACK       (4),
        .ADDR_W        (20),
        .TICKS_PER_SEC (100),
        .SEC_W         (6),
        .SPEED_W       (3)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_init_done   (i_init_done),
        .i_key_rec     (i_key_rec),
        .i_key_play    (i_key_play),
        .i_key_stop    (i_key_stop),
        .i_track       (i_track),
        .i_fast        (i_fast),
        .i_speed       (i_speed),
        .i_rec_addr    (i_rec_addr),
        .i_play_done   (i_play_done),
        .o_state       (o_state),
        .o_rec_run     (o_rec_run),
        .o_rec_pause   (o_rec_pause),
        .o_play_run    (o_play_run),
        .o_play_pause  (o_play_pause),
        .o_stop        (o_stop),
        .o_sram_wr     (o_sram_wr),
        .o_base_addr   (o_base_addr),
        .o_play_len    (o_play_len),
        .o_track_valid (o_track_valid),
        .o_seconds     (o_seconds)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic press_rec();
        i_key_rec = 1'b1; tick(); i_key_rec = 1'b0;
    endtask

    task automatic press_play();
        i_key_play = 1'b1; tick(); i_key_play = 1'b0;
    endtask

    task automatic press_stop();
        i_key_stop = 1'b1; tick(); i_key_stop = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_init_done = 1'b0; i_key_rec = 1'b0; i_key_play = 1'b0;
        i_key_stop = 1'b0; i_track = 2'd0; i_fast = 1'b0; i_speed = 3'd0;
        i_rec_addr = 20'd0; i_play_done = 1'b0;
        tick(3);
        total++; if ({o_state, o_rec_run, o_rec_pause, o_play_run, o_play_pause, o_stop, o_sram_wr} !== 9'd0)
            $display("FAIL reset_ctrl got=%b exp=0", {o_state, o_rec_run, o_rec_pause, o_play_run, o_play_pause, o_stop, o_sram_wr}); else passed++;
        total++; if ({o_base_addr, o_play_len, o_track_valid, o_seconds} !== 50'd0)
            $display("FAIL reset_data got=%h exp=0", {o_base_addr, o_play_len, o_track_valid, o_seconds}); else passed++;
        i_rst_n = 1'b1;
        tick();
        total++; if (o_state !== 3'd0) $display("FAIL idle_hold state=%0d exp=0", o_state); else passed++;
        i_init_done = 1'b1;
        tick();
        total++; if (o_state !== 3'd1 || o_stop !== 1'b1) $display("FAIL init_wait state=%0d stop=%b exp=1/1", o_state, o_stop); else passed++;
        total++; if (o_track_valid !== 4'b0000) $display("FAIL init_valid got=%b exp=0000", o_track_valid); else passed++;
    endtask

    task automatic test_record();
        i_track = 2'd2;
        press_rec();
        total++; if (o_state !== 3'd2 || o_rec_run !== 1'b1 || o_sram_wr !== 1'b1 || o_stop !== 1'b0)
            $display("FAIL rec_enter state=%0d run=%b wr=%b stop=%b exp=2/1/1/0", o_state, o_rec_run, o_sram_wr, o_stop); else passed++;
        total++; if (o_base_addr !== 20'h80000) $display("FAIL rec_base got=%h exp=80000", o_base_addr); else passed++;
        i_rec_addr = 20'd250;
        press_rec();
        total++; if (o_state !== 3'd3 || o_rec_pause !== 1'b1 || o_sram_wr !== 1'b0)
            $display("FAIL rec_pause state=%0d pause=%b wr=%b exp=3/1/0", o_state, o_rec_pause, o_sram_wr); else passed++;
        press_rec();
        total++; if (o_state !== 3'd2) $display("FAIL rec_resume state=%0d exp=2", o_state); else passed++;
        i_rec_addr = 20'd500;
        press_stop();
        total++; if (o_state !== 3'd1 || o_track_valid !== 4'b0100)
            $display("FAIL rec_stop state=%0d valid=%b exp=1/0100", o_state, o_track_valid); else passed++;
        i_rec_addr = 20'd0;
    endtask

    task automatic test_play_select();
        i_track = 2'd1;
        press_play();
        total++; if (o_state !== 3'd1) $display("FAIL play_invalid state=%0d exp=1", o_state); else passed++;
        i_track = 2'd2;
        press_play();
        total++; if (o_state !== 3'd4 || o_play_run !== 1'b1 || o_sram_wr !== 1'b0)
            $display("FAIL play_enter state=%0d run=%b wr=%b exp=4/1/0", o_state, o_play_run, o_sram_wr); else passed++;
        total++; if (o_play_len !== 20'd500) $display("FAIL play_len got=%0d exp=500", o_play_len); else passed++;
        press_stop();
        total++; if (o_state !== 3'd1) $display("FAIL play_stop state=%0d exp=1", o_state); else passed++;
    endtask

    task automatic test_rec_wins();
        i_track = 2'd1;
        i_key_rec = 1'b1; i_key_play = 1'b1;
        tick();
        i_key_rec = 1'b0; i_key_play = 1'b0;
        total++; if (o_state !== 3'd2) $display("FAIL rec_wins state=%0d exp=2", o_state); else passed++;
        press_play();
        total++; if (o_state !== 3'd2 || o_play_run !== 1'b0)
            $display("FAIL rec_ignore_play state=%0d run=%b exp=2/0", o_state, o_play_run); else passed++;
        press_stop();
        total++; if (o_track_valid !== 4'b0100) $display("FAIL empty_take valid=%b exp=0100", o_track_valid); else passed++;
    endtask

    task automatic test_autostop();
        i_track = 2'd3;
        press_rec();
        i_rec_addr = 20'h3FFFE;
        tick();
        total++; if (o_state !== 3'd2) $display("FAIL auto_early state=%0d exp=2", o_state); else passed++;
        i_rec_addr = 20'h3FFFF;
        tick();
        i_rec_addr = 20'd0;
        total++; if (o_state !== 3'd1 || o_track_valid !== 4'b1100)
            $display("FAIL auto_stop state=%0d valid=%b exp=1/1100", o_state, o_track_valid); else passed++;
        press_play();
        total++; if (o_play_len !== 20'h40000 || o_base_addr !== 20'hC0000)
            $display("FAIL auto_len len=%h base=%h exp=40000/c0000", o_play_len, o_base_addr); else passed++;
        press_play();
        total++; if (o_state !== 3'd5 || o_play_pause !== 1'b1)
            $display("FAIL play_pause state=%0d pause=%b exp=5/1", o_state, o_play_pause); else passed++;
        press_stop();
        total++; if (o_state !== 3'd1) $display("FAIL pause_stop state=%0d exp=1", o_state); else passed++;
    endtask

    task automatic test_timer();
        i_track = 2'd2; i_fast = 1'b1; i_speed = 3'd1;
        press_play();
        tick(99);
        total++; if (o_seconds !== 6'd1) $display("FAIL fast_99 got=%0d exp=1", o_seconds); else passed++;
        tick();
        total++; if (o_seconds !== 6'd2) $display("FAIL fast_100 got=%0d exp=2", o_seconds); else passed++;
        press_stop();
        total++; if (o_seconds !== 6'd0) $display("FAIL stop_clear got=%0d exp=0", o_seconds); else passed++;
        i_fast = 1'b0;
        press_play();
        tick(399);
        total++; if (o_seconds !== 6'd1) $display("FAIL slow_399 got=%0d exp=1", o_seconds); else passed++;
        tick();
        total++; if (o_seconds !== 6'd2) $display("FAIL slow_400 got=%0d exp=2", o_seconds); else passed++;
        press_play();
        tick(300);
        total++; if (o_state !== 3'd5 || o_seconds !== 6'd2)
            $display("FAIL pause_hold state=%0d sec=%0d exp=5/2", o_state, o_seconds); else passed++;
        press_play();
        total++; if (o_state !== 3'd4 || o_seconds !== 6'd2)
            $display("FAIL pause_resume state=%0d sec=%0d exp=4/2", o_state, o_seconds); else passed++;
    endtask

    task automatic test_done();
        i_key_play = 1'b1; i_play_done = 1'b1;
        tick();
        i_key_play = 1'b0; i_play_done = 1'b0;
`ifdef LOOP_PLAY_EN
        total++; if (o_state !== 3'd4 || o_play_run !== 1'b0 || o_seconds !== 6'd0)
            $display("FAIL loop_drop state=%0d run=%b sec=%0d exp=4/0/0", o_state, o_play_run, o_seconds); else passed++;
        tick();
        total++; if (o_state !== 3'd4 || o_play_run !== 1'b1)
            $display("FAIL loop_resume state=%0d run=%b exp=4/1", o_state, o_play_run); else passed++;
        press_stop();
`endif
        total++; if (o_state !== 3'd1 || o_stop !== 1'b1 || o_seconds !== 6'd0)
            $display("FAIL done_wait state=%0d stop=%b sec=%0d exp=1/1/0", o_state, o_stop, o_seconds); else passed++;
    endtask

    task automatic test_reset_mid_record();
        i_track = 2'd0;
        press_rec();
        i_rec_addr = 20'd123;
        tick(5);
        i_rst_n = 1'b0;
        #1;
        total++; if (o_state !== 3'd0 || o_rec_run !== 1'b0 || o_track_valid !== 4'b0000 || o_play_len !== 20'd0)
            $display("FAIL reset_discard state=%0d run=%b valid=%b len=%0d exp=0/0/0000/0", o_state, o_rec_run, o_track_valid, o_play_len); else passed++;
        tick(2);
        i_rst_n = 1'b1;
        i_rec_addr = 20'd0;
        tick();
        total++; if (o_state !== 3'd1 || o_track_valid !== 4'b0000)
            $display("FAIL reset_rewait state=%0d valid=%b exp=1/0000", o_state, o_track_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_record();
        test_play_select();
        test_rec_wins();
        test_autostop();
        test_timer();
        test_done();
        test_reset_mid_record();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
